// File: rtl/rps_round_ctrl.sv
// Round sequencer for three-player rock-paper-scissors: collects moves, eliminates losers, reports winner.
// Optional macro RPS_TIMEOUT_EN enables the COLLECT timeout and forfeit-by-absence.
module rps_round_ctrl #(
    parameter int TIMEOUT    = 15,
    parameter int MAX_ROUNDS = 7
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       VALID_A,
    input  logic       VALID_B,
    input  logic       VALID_C,
    input  logic [1:0] MOVE_A,
    input  logic [1:0] MOVE_B,
    input  logic [1:0] MOVE_C,
    output logic [2:0] READY,
    output logic [2:0] ACTIVE,
    output logic [2:0] WINNER,
    output logic       DONE,
    output logic [2:0] ROUND,
    output logic       BUSY
);
    typedef enum logic [1:0] {IDLE, COLLECT, RESOLVE, REPORT} state_t;

    state_t state, state_nxt;
    logic [2:0] active, active_nxt, winner, winner_nxt;
    logic [2:0] latched, latched_nxt, round, round_nxt;
    logic [2:0][1:0] mv, mv_nxt, mv_in;
    logic [2:0] hs, sub, surv, res_active;
    logic rock, sci, pap;
    logic [1:0] win_shape;
    logic expired;

`ifdef RPS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer, timer_nxt;
    assign expired = (timer == TW'(TIMEOUT - 1));
`else
    assign expired = 1'b0;
`endif

    // Bit 2 = A, bit 1 = B, bit 0 = C throughout.
    assign mv_in  = {MOVE_A, MOVE_B, MOVE_C};
    assign READY  = (state == COLLECT) ? (active & ~latched) : 3'b000;
    assign hs     = {VALID_A, VALID_B, VALID_C} & READY;
    assign ACTIVE = active;
    assign WINNER = winner;
    assign ROUND  = round;
    assign DONE   = (state == REPORT);
    assign BUSY   = (state != IDLE);

    // Round outcome from the latched moves; 00 or missing move is a forfeit.
    always_comb begin
        sub  = 3'b000;
        rock = 1'b0;
        sci  = 1'b0;
        pap  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sub[i] = active[i] & latched[i] & (mv[i] != 2'b00);
            if (sub[i]) begin
                rock = rock | (mv[i] == 2'b01);
                sci  = sci  | (mv[i] == 2'b10);
                pap  = pap  | (mv[i] == 2'b11);
            end
        end
        case ({rock, sci, pap})
            3'b110:  win_shape = 2'b01;
            3'b011:  win_shape = 2'b10;
            3'b101:  win_shape = 2'b11;
            default: win_shape = 2'b00;   // one or three shapes: everyone survives
        endcase
        surv = 3'b000;
        for (int i = 0; i < 3; i++)
            surv[i] = sub[i] & ((win_shape == 2'b00) | (mv[i] == win_shape));
        res_active = (sub == 3'b000) ? active : surv;
    end

    always_comb begin
        state_nxt   = state;
        active_nxt  = active;
        winner_nxt  = winner;
        latched_nxt = latched;
        round_nxt   = round;
        mv_nxt      = mv;
`ifdef RPS_TIMEOUT_EN
        timer_nxt   = timer;
`endif
        case (state)
            IDLE: begin
                if (START) begin
                    active_nxt  = 3'b111;
                    round_nxt   = 3'd1;
                    winner_nxt  = 3'b000;
                    latched_nxt = 3'b000;
`ifdef RPS_TIMEOUT_EN
                    timer_nxt   = '0;
`endif
                    state_nxt   = COLLECT;
                end
            end
            COLLECT: begin
                for (int i = 0; i < 3; i++) begin
                    if (hs[i]) begin
                        latched_nxt[i] = 1'b1;
                        mv_nxt[i]      = mv_in[i];
                    end
                end
`ifdef RPS_TIMEOUT_EN
                timer_nxt = timer + 1'b1;
`endif
                if (((latched_nxt & active) == active) || expired)
                    state_nxt = RESOLVE;
            end
            RESOLVE: begin
                active_nxt = res_active;
                if ($onehot(res_active) || (round == 3'(MAX_ROUNDS))) begin
                    winner_nxt = res_active;
                    state_nxt  = REPORT;
                end else begin
                    round_nxt   = round + 3'd1;
                    latched_nxt = 3'b000;
`ifdef RPS_TIMEOUT_EN
                    timer_nxt   = '0;
`endif
                    state_nxt   = COLLECT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            active  <= 3'b000;
            winner  <= 3'b000;
            latched <= 3'b000;
            round   <= 3'd0;
            mv      <= '0;
`ifdef RPS_TIMEOUT_EN
            timer   <= '0;
`endif
        end else begin
            state   <= state_nxt;
            active  <= active_nxt;
            winner  <= winner_nxt;
            latched <= latched_nxt;
            round   <= round_nxt;
            mv      <= mv_nxt;
`ifdef RPS_TIMEOUT_EN
            timer   <= timer_nxt;
`endif
        end
    end
endmodule

// File: doc/rps_round_ctrl.md
# rps_round_ctrl

Round sequencer for the three-player rock-paper-scissors game. It collects one move per active player through a valid/ready handshake and resolves each round. Losers are eliminated round by round until one player remains or the round limit is hit. It drives the game-state signals (`ACTIVE`, `WINNER`) that the display stage prints every clock. `WINNER` uses the display's encoding: A=bit2, B=bit1, C=bit0, `3'b111` = DRAW.

## Interface
- `TIMEOUT`, 15: cycles `COLLECT` waits for moves before absent players forfeit; must be ≥1.
- `MAX_ROUNDS`, 7: round limit, range 1..7.

- `CLK` in 1: clock, rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `START` in 1: begin a game; sampled only in `IDLE`.
- `VALID_A`/`VALID_B`/`VALID_C` in 1: move offered.
- `MOVE_A`/`MOVE_B`/`MOVE_C` in 2: move encoding is 01 rock, 10 scissors, 11 paper; 00 is a forfeit.
- `READY` out 3: {A,B,C}, move accepted this cycle if `VALID_x` & `READY[x]`.
- `ACTIVE` out 3: players still in the game.
- `WINNER` out 3: result mask; `000` until a game completes.
- `DONE` out 1: one-cycle pulse when `WINNER` becomes valid.
- `ROUND` out 3: current round number, 1-based.
- `BUSY` out 1: high in `COLLECT`/`RESOLVE`/`REPORT`.

## Operation
- States: `IDLE`, `COLLECT`, `RESOLVE`, `REPORT`.
- `IDLE` + `START`:
  - `ACTIVE`←111, `ROUND`←1, `WINNER`←000.
  - Clear latched moves; timer←0; go to `COLLECT`.
- `COLLECT`:
  - `READY[x]` = `ACTIVE[x]` & not-yet-latched.
  - A handshake latches `MOVE_x` and drops `READY[x]` the next cycle.
  - Timer increments each cycle.
  - Exit to `RESOLVE` when every active player has latched, or timer == `TIMEOUT`-1.
- `RESOLVE` (one cycle):
  - Forfeiters = active players with no latch, or with latched move 00.
  - Submitters = remaining active players.
  - Survivors among submitters, by the set of distinct shapes:
    - 1 or 3 distinct shapes: all submitters survive.
    - 2 distinct shapes: only holders of the winning shape survive (rock>scissors, scissors>paper, paper>rock).
  - No submitters at all: `ACTIVE` unchanged (void round).
  - Otherwise `ACTIVE`←survivors; forfeiters are removed.
- Termination, evaluated on the new `ACTIVE`:
  - One bit set: `WINNER`←`ACTIVE` → `REPORT`.
  - `ROUND` == `MAX_ROUNDS`: `WINNER`←`ACTIVE` (so 111 = DRAW) → `REPORT`.
  - Otherwise `ROUND`+1, clear latches, timer←0 → `COLLECT`.
- `REPORT`: `DONE`=1 for one cycle, then `IDLE`. `WINNER`/`ACTIVE`/`ROUND` hold until the next `START`.
- `START` outside `IDLE` is ignored. `VALID_x` while `READY[x]`=0 is ignored.

## Timing
- Reset values: `READY`=000, `ACTIVE`=000, `WINNER`=000, `DONE`=0, `ROUND`=0, `BUSY`=0, state `IDLE`.
- `RST` mid-game aborts immediately; latched moves and timer are cleared.
- `START` at edge n → `COLLECT` and `READY`=111 from edge n+1.
- All moves accepted at edge k → `RESOLVE` during cycle k+1 → at edge k+2, either `REPORT` (`DONE`=1, `WINNER` valid) or next-round `COLLECT`.
- Timeout: if no exit, `COLLECT` lasts exactly `TIMEOUT` cycles.
- A handshake on the same edge as the timeout counts as a submission.
- Timer width is $clog2(`TIMEOUT`+1). `ROUND` never wraps; the `MAX_ROUNDS` check precedes the increment.

## Configuration
- `RPS_TIMEOUT_EN` defined: timeout and forfeit-by-absence behave as above.
- `RPS_TIMEOUT_EN` undefined:
  - No timer; `COLLECT` exits only when all active players have latched.
  - `TIMEOUT` is unused.
  - A move of 00 is still a forfeit.

## Test plan
- **Single-round win:** `START`; at the first `COLLECT` cycle, A=01, B=10, C=10 all valid → `WINNER`=100, `ROUND`=1, `DONE` pulses 2 cycles after acceptance, `ACTIVE`=100.
- **Two-round elimination:**
  - Round 1: A=11, B=11, C=01 → `ACTIVE`=110, `ROUND`=2, `READY`=110.
  - Round 2: A=01, B=10 → `WINNER`=100, `DONE` pulse.
- **Draw to limit:** all players play rock every round with `MAX_ROUNDS`=7 → 7 rounds, `WINNER`=111, `ROUND`=7, `ACTIVE`=111.
- **Forfeit by timeout** (macro defined, `TIMEOUT`=15): only B submits 10 → `RESOLVE` after 15 `COLLECT` cycles, `WINNER`=010.
- **Reset mid-game:** `RST` pulse during round 2 `COLLECT` → all outputs reset values asynchronously; a new `START` gives `ROUND`=1, `ACTIVE`=111.
- **Macro undefined:** no `VALID` for 100 cycles → `BUSY`=1, `READY`=111 held, no `DONE`; then all three submit rock → next round starts, `ROUND`=2.
